// File: rtl/sr_ctrl_pkg.sv
// Shared types and helpers for the SR latch sequencing controller.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE_S,
        DRIVE_R,
        CHECK
    } ctrl_state_t;

    localparam int unsigned MIN_SYNC_STAGES     = 2;
    localparam int unsigned MIN_DEBOUNCE_CYCLES = 1;
    localparam int unsigned MIN_PULSE_CYCLES    = 1;

    // Parameters below their floor are raised to it rather than breaking the logic.
    function automatic int unsigned clamp_min(input int unsigned value, input int unsigned floor);
        return (value < floor) ? floor : value;
    endfunction

    // Edges from the first sample of a stable new request to the first drive cycle.
    function automatic int unsigned drive_latency(input int unsigned sync_stages,
                                                  input int unsigned debounce_cycles);
        return clamp_min(sync_stages, MIN_SYNC_STAGES)
             + clamp_min(debounce_cycles, MIN_DEBOUNCE_CYCLES) + 1;
    endfunction

endpackage

// File: rtl/input_conditioner.sv
// Synchroniser, debounce filter and rising-edge detector for one async request.
module input_conditioner
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic event_o
);

    localparam int unsigned NSync = clamp_min(SYNC_STAGES, MIN_SYNC_STAGES);
    localparam int unsigned NDeb  = clamp_min(DEBOUNCE_CYCLES, MIN_DEBOUNCE_CYCLES);
    localparam int unsigned CntW  = (NDeb > 1) ? $clog2(NDeb) : 1;

    logic [NSync-1:0] sync_q;
    logic             sync_lvl;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             filt_prev_q;

    assign sync_lvl = sync_q[NSync-1];

    // Synchroniser chain; bit 0 is the only flop that sees the raw input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NSync-2:0], async_i};
        end
    end

    // Filtered level moves only after NDeb consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_lvl != filt_q) begin
            if (cnt_q == CntW'(NDeb - 1)) begin
                filt_d = sync_lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and previous filtered level for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    // Falling edges of the filtered level are deliberately ignored.
    assign event_o = filt_q & ~filt_prev_q;

endmodule

// File: rtl/srgate.sv
// Level-sensitive SR latch with active-low clear; set dominates if ever both are high.
module srgate (
    input  logic s_i,
    input  logic r_i,
    input  logic rst_ni,
    output logic q_o
);

    // Transparent storage element: the latch being sequenced, not a flop.
    always_latch begin
        if (!rst_ni) begin
            q_o <= 1'b0;
        end else if (s_i) begin
            q_o <= 1'b1;
        end else if (r_i) begin
            q_o <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequences timed S/R pulses into an SR latch from debounced push-button requests.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 2
) (
    input  logic CLK,
    input  logic nReset,
    input  logic SET_REQ,
    input  logic RST_REQ,
    input  logic Q_FB,
    output logic S,
    output logic R,
    output logic BUSY,
    output logic CONFLICT,
    output logic FAULT
);

    localparam int unsigned NPulse = clamp_min(PULSE_CYCLES, MIN_PULSE_CYCLES);
    localparam int unsigned PCntW  = (NPulse > 1) ? $clog2(NPulse) : 1;

    ctrl_state_t      state_q, state_d;
    logic [PCntW-1:0] pulse_q, pulse_d;
    logic             pend_set_q, pend_set_d;
    logic             pend_rst_q, pend_rst_d;
    logic             exp_q, exp_d;
    logic             fault_q, fault_d;
    logic             conflict_q, conflict_d;
    logic             s_q, r_q;
    logic             set_evt, rst_evt;
    logic             want_set, want_rst;

    input_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond_set (
        .clk_i  (CLK),
        .rst_ni (nReset),
        .async_i(SET_REQ),
        .event_o(set_evt)
    );

    input_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond_rst (
        .clk_i  (CLK),
        .rst_ni (nReset),
        .async_i(RST_REQ),
        .event_o(rst_evt)
    );

    // Next-state, pending capture, conflict and fault decisions.
    always_comb begin
        state_d    = state_q;
        pulse_d    = pulse_q;
        pend_set_d = pend_set_q;
        pend_rst_d = pend_rst_q;
        exp_d      = exp_q;
        fault_d    = fault_q;
        conflict_d = 1'b0;
        want_set   = 1'b0;
        want_rst   = 1'b0;

        // Requests seen while busy are remembered, one of each kind.
        if (state_q != IDLE) begin
            if (set_evt) pend_set_d = 1'b1;
            if (rst_evt) pend_rst_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                pulse_d = '0;
                if (pend_set_q || pend_rst_q) begin
                    // Pending work is served first; fresh events wait their turn.
                    want_set   = pend_set_q;
                    want_rst   = pend_rst_q;
                    pend_set_d = set_evt;
                    pend_rst_d = rst_evt;
                end else begin
                    want_set = set_evt;
                    want_rst = rst_evt;
                end
                if (want_set && want_rst) begin
                    conflict_d = 1'b1;
                end else if (want_set && !Q_FB) begin
                    state_d = DRIVE_S;
                    exp_d   = 1'b1;
                end else if (want_rst && Q_FB) begin
                    state_d = DRIVE_R;
                    exp_d   = 1'b0;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (pulse_q == PCntW'(NPulse - 1)) begin
                    state_d = CHECK;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            CHECK: begin
                if (Q_FB != exp_q) fault_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered drives; S and R decode from one state so they are exclusive.
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            pulse_q    <= '0;
            pend_set_q <= 1'b0;
            pend_rst_q <= 1'b0;
            exp_q      <= 1'b0;
            fault_q    <= 1'b0;
            conflict_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            pend_set_q <= pend_set_d;
            pend_rst_q <= pend_rst_d;
            exp_q      <= exp_d;
            fault_q    <= fault_d;
            conflict_q <= conflict_d;
            s_q        <= (state_d == DRIVE_S);
            r_q        <= (state_d == DRIVE_R);
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign BUSY     = (state_q != IDLE);
    assign CONFLICT = conflict_q;
    assign FAULT    = fault_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl driving a real srgate, with a pulse scoreboard.
module tb_sr_latch_ctrl;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;
    localparam int unsigned PULSE = 2;
    localparam int LAT = SYNC + DEB + 1;
    localparam int K_S = 0;
    localparam int K_R = 1;
    localparam int K_C = 2;

    logic CLK = 1'b0;
    logic nReset = 1'b1;
    logic SET_REQ = 1'b0;
    logic RST_REQ = 1'b0;
    logic tie_low = 1'b0;
    logic latch_q;
    logic Q_FB;
    logic S, R, BUSY, CONFLICT, FAULT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0;

    typedef struct {
        int kind;
        int at;
    } exp_t;
    exp_t sb[$];

    logic mon_prev[3];
    int   mon_len[3];
    logic busy_prev;
    int   busy_len;

    assign Q_FB = tie_low ? 1'b0 : latch_q;

    sr_latch_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_CYCLES   (PULSE)
    ) dut (
        .CLK     (CLK),
        .nReset  (nReset),
        .SET_REQ (SET_REQ),
        .RST_REQ (RST_REQ),
        .Q_FB    (Q_FB),
        .S       (S),
        .R       (R),
        .BUSY    (BUSY),
        .CONFLICT(CONFLICT),
        .FAULT   (FAULT)
    );

    srgate u_latch (
        .s_i   (S),
        .r_i   (R),
        .rst_ni(nReset),
        .q_o   (latch_q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic string kname(input int k);
        return (k == K_S) ? "S" : (k == K_R) ? "R" : "CONFLICT";
    endfunction

    task automatic clear_mon();
        for (int k = 0; k < 3; k++) begin
            mon_prev[k] = 1'b0;
            mon_len[k]  = 0;
        end
        busy_prev = 1'b0;
        busy_len  = 0;
    endtask

    task automatic expect_pulse(input int k, input int at);
        exp_t e;
        e.kind = k;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Per-cycle monitor: exclusivity, pulse starts against the scoreboard, widths.
    task automatic sample();
        logic cur;
        exp_t e;
        checks++;
        assert (!(S && R)) else begin
            errors++;
            $error("FAIL s_r_exclusive: S=%0b R=%0b, required not both 1", S, R);
        end
        for (int k = 0; k < 3; k++) begin
            cur = (k == K_S) ? S : (k == K_R) ? R : CONFLICT;
            if (cur && !mon_prev[k]) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_%s: pulse at cycle %0d, none required", kname(k), cyc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check({"kind_", kname(k)}, k, e.kind);
                    check({"cycle_", kname(k)}, cyc, e.at);
                end
                mon_len[k] = 1;
            end else if (cur) begin
                mon_len[k]++;
            end else if (mon_prev[k]) begin
                check({"width_", kname(k)}, mon_len[k], (k == K_C) ? 1 : PULSE);
            end
            mon_prev[k] = cur;
        end
        if (BUSY) begin
            busy_len++;
        end else if (busy_prev) begin
            check("busy_len", busy_len, PULSE + 1);
            busy_len = 0;
        end
        busy_prev = BUSY;
    endtask

    task automatic step();
        @(negedge CLK);
        sample();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic apply_reset();
        nReset = 1'b0;
        #1;
        check("rst_S", S, 0);
        check("rst_R", R, 0);
        check("rst_BUSY", BUSY, 0);
        check("rst_CONFLICT", CONFLICT, 0);
        check("rst_FAULT", FAULT, 0);
        check("rst_latch_q", latch_q, 0);
        clear_mon();
        steps(2);
        nReset = 1'b1;
    endtask

    initial begin
        clear_mon();
        #2;
        apply_reset();
        steps(2);

        // 1: held set request, latch starts clear.
        c0 = cyc;
        SET_REQ = 1'b1;
        expect_pulse(K_S, c0 + LAT);
        wait_cyc(c0 + LAT);
        check("t1_s_first", S, 1);
        check("t1_busy", BUSY, 1);
        wait_cyc(c0 + 20);
        SET_REQ = 1'b0;
        check("t1_q", latch_q, 1);
        check("t1_fault", FAULT, 0);
        check("t1_sb_empty", sb.size(), 0);
        steps(12);

        // 2: sub-debounce glitch, then a real reset request.
        RST_REQ = 1'b1;
        steps(DEB - 1);
        RST_REQ = 1'b0;
        steps(15);
        check("t2_glitch_q", latch_q, 1);
        c0 = cyc;
        RST_REQ = 1'b1;
        expect_pulse(K_R, c0 + LAT);
        steps(10);
        RST_REQ = 1'b0;
        steps(12);
        check("t2_q", latch_q, 0);
        check("t2_sb_empty", sb.size(), 0);

        // 3: simultaneous requests are rejected.
        c0 = cyc;
        SET_REQ = 1'b1;
        RST_REQ = 1'b1;
        expect_pulse(K_C, c0 + LAT);
        wait_cyc(c0 + LAT);
        check("t3_conflict", CONFLICT, 1);
        step();
        check("t3_conflict_gone", CONFLICT, 0);
        steps(8);
        SET_REQ = 1'b0;
        RST_REQ = 1'b0;
        steps(12);
        check("t3_q", latch_q, 0);
        check("t3_sb_empty", sb.size(), 0);

        // 4: reset request lands during the set drive and is served afterwards.
        c0 = cyc;
        SET_REQ = 1'b1;
        expect_pulse(K_S, c0 + LAT);
        steps(2);
        RST_REQ = 1'b1;
        expect_pulse(K_R, c0 + LAT + PULSE + 2);
        steps(20);
        SET_REQ = 1'b0;
        RST_REQ = 1'b0;
        steps(12);
        check("t4_q", latch_q, 0);
        check("t4_sb_empty", sb.size(), 0);

        // 5: feedback stuck low raises a sticky fault.
        tie_low = 1'b1;
        c0 = cyc;
        SET_REQ = 1'b1;
        expect_pulse(K_S, c0 + LAT);
        wait_cyc(c0 + LAT + PULSE);
        check("t5_fault_in_check", FAULT, 0);
        step();
        check("t5_fault_set", FAULT, 1);
        steps(10);
        SET_REQ = 1'b0;
        steps(12);
        RST_REQ = 1'b1;
        steps(12);
        RST_REQ = 1'b0;
        steps(12);
        check("t5_fault_sticky", FAULT, 1);
        check("t5_sb_empty", sb.size(), 0);
        apply_reset();
        tie_low = 1'b0;
        steps(2);

        // 6: reset asserted in the first cycle of a reset drive.
        c0 = cyc;
        SET_REQ = 1'b1;
        expect_pulse(K_S, c0 + LAT);
        steps(12);
        SET_REQ = 1'b0;
        steps(12);
        check("t6_q_set", latch_q, 1);
        c0 = cyc;
        RST_REQ = 1'b1;
        expect_pulse(K_R, c0 + LAT);
        wait_cyc(c0 + LAT);
        check("t6_r_first", R, 1);
        check("t6_busy_first", BUSY, 1);
        nReset = 1'b0;
        #1;
        check("t6_r_cut", R, 0);
        check("t6_busy_cut", BUSY, 0);
        check("t6_s_cut", S, 0);
        check("t6_sb_empty_cut", sb.size(), 0);
        clear_mon();
        RST_REQ = 1'b0;
        steps(3);
        nReset = 1'b1;
        steps(25);
        check("t6_no_drive", sb.size(), 0);
        check("t6_latch_q", latch_q, 0);
        check("t6_fault", FAULT, 0);
        check("t6_busy_idle", BUSY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
